// File: rtl/ime_sad_pingpong_buffer_pkg.sv
// Shared widths, defaults and fill-state encoding for the IME SAD ping-pong buffer.
// The optional per-partition minimum trackers are enabled with `define IME_SAD_BUF_MIN_EN.
package ime_sad_pingpong_buffer_pkg;

    localparam int SAD_WIDTH_DEF = 16;

    function automatic int aw_of(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int bw_of(input int blocks);
        return (blocks > 1) ? $clog2(blocks) : 1;
    endfunction

    function automatic int lw_of(input int lanes);
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction

    // Number of committed banks waiting to be consumed.
    typedef enum logic [1:0] {
        CNT_EMPTY = 2'd0,
        CNT_ONE   = 2'd1,
        CNT_FULL  = 2'd2
    } fill_state_t;

endpackage

// File: rtl/ime_sad_buf_bank.sv
// One partition's storage: two banks of DEPTH words, one write port and a
// registered read port (1-cycle latency, output holds between reads).
module ime_sad_buf_bank #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic             wr_bank,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic             rd_bank,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [2][DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_bank][wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_bank][rd_addr];
        end
    end

endmodule

// File: rtl/ime_sad_pingpong_buffer.sv
// Double-buffered SAD store: fill one bank while the other is read across all partitions.
// Optional per-bank min trackers are built only when IME_SAD_BUF_MIN_EN is defined.
module ime_sad_pingpong_buffer
    import ime_sad_pingpong_buffer_pkg::*;
#(
    parameter int  SAD_WIDTH = SAD_WIDTH_DEF,
    parameter int  LANES     = 4,
    parameter int  BLOCKS    = 3,
    parameter int  DEPTH     = 32,
    localparam int AW        = aw_of(DEPTH),
    localparam int BW        = bw_of(BLOCKS)
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic                              wr_en_i,
    input  logic [BW-1:0]                     wr_block_i,
    input  logic [AW-1:0]                     wr_addr_i,
    input  logic [LANES*SAD_WIDTH-1:0]        wr_sad_i,
    input  logic                              wr_last_i,
    output logic                              wr_rdy_o,
    input  logic                              rd_en_i,
    input  logic [AW-1:0]                     rd_addr_i,
    input  logic                              rd_done_i,
    output logic                              rd_rdy_o,
    output logic                              rd_valid_o,
    output logic [BLOCKS*LANES*SAD_WIDTH-1:0] rd_sad_o,
`ifdef IME_SAD_BUF_MIN_EN
    output logic [BLOCKS*SAD_WIDTH-1:0]       min_sad_o,
    output logic [BLOCKS*(AW+lw_of(LANES))-1:0] min_idx_o,
`endif
    output logic                              ovf_o
);

    localparam int WW = LANES * SAD_WIDTH;

    fill_state_t state, state_nxt;
    logic        wb, rb, wb_nxt, rb_nxt;
    logic        blk_ok, wr_accept, commit, rel, rd_accept;

    always_comb begin
        wr_rdy_o  = (state != CNT_FULL);
        rd_rdy_o  = (state != CNT_EMPTY);
        blk_ok    = ({1'b0, wr_block_i} < (BW+1)'(BLOCKS));
        wr_accept = wr_en_i & wr_rdy_o & blk_ok;
        // An out-of-range partition drops the data but still commits.
        commit    = wr_en_i & wr_last_i & wr_rdy_o;
        rel       = rd_done_i & rd_rdy_o;
        rd_accept = rd_en_i & rd_rdy_o;
        state_nxt = state;
        wb_nxt    = wb ^ commit;
        rb_nxt    = rb ^ rel;
        if (commit && !rel) begin
            state_nxt = (state == CNT_EMPTY) ? CNT_ONE : CNT_FULL;
        end else if (rel && !commit) begin
            state_nxt = (state == CNT_FULL) ? CNT_ONE : CNT_EMPTY;
        end
    end

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            state      <= CNT_EMPTY;
            wb         <= 1'b0;
            rb         <= 1'b0;
            rd_valid_o <= 1'b0;
            ovf_o      <= 1'b0;
        end else begin
            state      <= state_nxt;
            wb         <= wb_nxt;
            rb         <= rb_nxt;
            rd_valid_o <= rd_accept;
            if (wr_en_i && !wr_rdy_o) begin
                ovf_o <= 1'b1;
            end
        end
    end

    for (genvar b = 0; b < BLOCKS; b++) begin : g_part
        ime_sad_buf_bank #(
            .WIDTH (WW),
            .DEPTH (DEPTH),
            .AW    (AW)
        ) u_bank (
            .clk     (clk),
            .rst     (rstn),
            .wr_en   (wr_accept && (wr_block_i == BW'(b))),
            .wr_bank (wb),
            .wr_addr (wr_addr_i),
            .wr_data (wr_sad_i),
            .rd_en   (rd_accept),
            .rd_bank (rb),
            .rd_addr (rd_addr_i),
            .rd_data (rd_sad_o[b*WW +: WW])
        );
    end

`ifdef IME_SAD_BUF_MIN_EN
    localparam int LW = lw_of(LANES);
    localparam int IW = AW + LW;

    logic [SAD_WIDTH-1:0] live_min [BLOCKS];
    logic [SAD_WIDTH-1:0] nxt_min  [BLOCKS];
    logic [SAD_WIDTH-1:0] bank_min [2][BLOCKS];
    logic [IW-1:0]        live_idx [BLOCKS];
    logic [IW-1:0]        nxt_idx  [BLOCKS];
    logic [IW-1:0]        bank_idx [2][BLOCKS];

    // Strict less-than in lane order keeps the lowest lane and earliest write on ties.
    always_comb begin
        for (int b = 0; b < BLOCKS; b++) begin
            nxt_min[b] = live_min[b];
            nxt_idx[b] = live_idx[b];
            if (wr_accept && (wr_block_i == BW'(b))) begin
                for (int l = 0; l < LANES; l++) begin
                    if (wr_sad_i[l*SAD_WIDTH +: SAD_WIDTH] < nxt_min[b]) begin
                        nxt_min[b] = wr_sad_i[l*SAD_WIDTH +: SAD_WIDTH];
                        nxt_idx[b] = {wr_addr_i, LW'(l)};
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            for (int b = 0; b < BLOCKS; b++) begin
                live_min[b]    <= '1;
                live_idx[b]    <= '0;
                bank_min[0][b] <= '1;
                bank_min[1][b] <= '1;
                bank_idx[0][b] <= '0;
                bank_idx[1][b] <= '0;
            end
        end else begin
            for (int b = 0; b < BLOCKS; b++) begin
                if (commit) begin
                    bank_min[wb][b] <= nxt_min[b];
                    bank_idx[wb][b] <= nxt_idx[b];
                    live_min[b]     <= '1;
                    live_idx[b]     <= '0;
                end else begin
                    live_min[b] <= nxt_min[b];
                    live_idx[b] <= nxt_idx[b];
                end
            end
        end
    end

    for (genvar b = 0; b < BLOCKS; b++) begin : g_min_out
        assign min_sad_o[b*SAD_WIDTH +: SAD_WIDTH] = bank_min[rb][b];
        assign min_idx_o[b*IW +: IW]               = bank_idx[rb][b];
    end
`endif

endmodule

// File: tb/tb_ime_sad_pingpong_buffer.sv
// Bench for ime_sad_pingpong_buffer: spec-level model checked every cycle plus literal pins.
module tb_ime_sad_pingpong_buffer;

    localparam int SW     = 16;
    localparam int LANES  = 4;
    localparam int BLOCKS = 3;
    localparam int DEPTH  = 32;
    localparam int AW     = 5;
    localparam int BW     = 2;
    localparam int LW     = 2;
    localparam int W      = LANES * SW;

    logic                  clk = 1'b0;
    logic                  rstn;
    logic                  wr_en, wr_last, rd_en, rd_done;
    logic [BW-1:0]         wr_block;
    logic [AW-1:0]         wr_addr, rd_addr;
    logic [W-1:0]          wr_sad;
    logic                  wr_rdy, rd_rdy, rd_valid, ovf;
    logic [BLOCKS*W-1:0]   rd_sad;
`ifdef IME_SAD_BUF_MIN_EN
    logic [BLOCKS*SW-1:0]      min_sad;
    logic [BLOCKS*(AW+LW)-1:0] min_idx;
`endif

    ime_sad_pingpong_buffer #(
        .SAD_WIDTH (SW),
        .LANES     (LANES),
        .BLOCKS    (BLOCKS),
        .DEPTH     (DEPTH)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .wr_en_i    (wr_en),
        .wr_block_i (wr_block),
        .wr_addr_i  (wr_addr),
        .wr_sad_i   (wr_sad),
        .wr_last_i  (wr_last),
        .wr_rdy_o   (wr_rdy),
        .rd_en_i    (rd_en),
        .rd_addr_i  (rd_addr),
        .rd_done_i  (rd_done),
        .rd_rdy_o   (rd_rdy),
        .rd_valid_o (rd_valid),
        .rd_sad_o   (rd_sad),
`ifdef IME_SAD_BUF_MIN_EN
        .min_sad_o  (min_sad),
        .min_idx_o  (min_idx),
`endif
        .ovf_o      (ovf)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_on = 1'b0;

    task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    // Behavioural model: two banks of plain arrays and a committed-bank count.
    logic [W-1:0]        m_mem [2][BLOCKS][DEPTH];
    int                  m_cnt;
    int                  m_wb, m_rb;
    bit                  m_valid, m_ovf;
    logic [BLOCKS*W-1:0] m_sad;
    bit                  t_wr, t_commit, t_rel;
    logic [W-1:0]        lw_words [BLOCKS][64];
    int                  lw_addrs [BLOCKS][64];
    int                  lw_n     [BLOCKS];
    logic [SW-1:0]       m_min    [2][BLOCKS];
    int                  m_idx    [2][BLOCKS];

    always @(posedge clk or posedge rstn) begin
        if (rstn) begin
            m_cnt = 0; m_wb = 0; m_rb = 0;
            m_valid = 1'b0; m_ovf = 1'b0; m_sad = '0;
            for (int b = 0; b < BLOCKS; b++) begin
                lw_n[b] = 0;
                for (int k = 0; k < 2; k++) begin
                    m_min[k][b] = '1;
                    m_idx[k][b] = 0;
                end
            end
        end else begin
            t_wr     = wr_en && (m_cnt < 2);
            t_commit = t_wr && wr_last;
            t_rel    = rd_done && (m_cnt > 0);
            m_valid  = rd_en && (m_cnt > 0);
            if (m_valid) begin
                for (int b = 0; b < BLOCKS; b++) m_sad[b*W +: W] = m_mem[m_rb][b][rd_addr];
            end
            if (wr_en && m_cnt >= 2) m_ovf = 1'b1;
            if (t_wr && int'(wr_block) < BLOCKS) begin
                m_mem[m_wb][wr_block][wr_addr] = wr_sad;
                if (lw_n[wr_block] < 64) begin
                    lw_words[wr_block][lw_n[wr_block]] = wr_sad;
                    lw_addrs[wr_block][lw_n[wr_block]] = int'(wr_addr);
                    lw_n[wr_block]++;
                end
            end
            if (t_commit) begin
                for (int b = 0; b < BLOCKS; b++) begin
                    m_min[m_wb][b] = '1;
                    m_idx[m_wb][b] = 0;
                    for (int i = 0; i < lw_n[b]; i++) begin
                        for (int l = 0; l < LANES; l++) begin
                            if (lw_words[b][i][l*SW +: SW] < m_min[m_wb][b]) begin
                                m_min[m_wb][b] = lw_words[b][i][l*SW +: SW];
                                m_idx[m_wb][b] = (lw_addrs[b][i] << LW) | l;
                            end
                        end
                    end
                    lw_n[b] = 0;
                end
                m_wb = 1 - m_wb;
            end
            if (t_rel) m_rb = 1 - m_rb;
            m_cnt = m_cnt + int'(t_commit) - int'(t_rel);
        end
    end

`ifdef IME_SAD_BUF_MIN_EN
    logic [BLOCKS*SW-1:0]      e_min;
    logic [BLOCKS*(AW+LW)-1:0] e_idx;
`endif

    always @(negedge clk) begin
        if (chk_on) begin
            check("wr_rdy", 256'(wr_rdy), 256'(m_cnt < 2));
            check("rd_rdy", 256'(rd_rdy), 256'(m_cnt > 0));
            check("rd_valid", 256'(rd_valid), 256'(m_valid));
            check("ovf", 256'(ovf), 256'(m_ovf));
            check("rd_sad", 256'(rd_sad), 256'(m_sad));
`ifdef IME_SAD_BUF_MIN_EN
            if (m_cnt > 0) begin
                for (int b = 0; b < BLOCKS; b++) begin
                    e_min[b*SW +: SW]           = m_min[m_rb][b];
                    e_idx[b*(AW+LW) +: (AW+LW)] = (AW+LW)'(m_idx[m_rb][b]);
                end
                check("min_sad", 256'(min_sad), 256'(e_min));
                check("min_idx", 256'(min_idx), 256'(e_idx));
            end
`endif
        end
    end

    function automatic logic [W-1:0] w4(input int a3, input int a2, input int a1, input int a0);
        return {SW'(a3), SW'(a2), SW'(a1), SW'(a0)};
    endfunction

    task automatic cyc(input logic we, input logic [BW-1:0] blk, input logic [AW-1:0] wa,
                       input logic [W-1:0] d, input logic last,
                       input logic re, input logic [AW-1:0] ra, input logic done);
        wr_en = we; wr_block = blk; wr_addr = wa; wr_sad = d; wr_last = last;
        rd_en = re; rd_addr = ra; rd_done = done;
        @(negedge clk); #1;
        wr_en = 1'b0; wr_last = 1'b0; rd_en = 1'b0; rd_done = 1'b0;
    endtask

    initial begin
        rstn = 1'b1;
        wr_en = 1'b0; wr_last = 1'b0; rd_en = 1'b0; rd_done = 1'b0;
        wr_block = '0; wr_addr = '0; rd_addr = '0; wr_sad = '0;
        repeat (2) @(negedge clk);
        #1 rstn = 1'b0;
        chk_on = 1'b1;
        check("rst_wr_rdy", 256'(wr_rdy), 256'(1));
        check("rst_rd_rdy", 256'(rd_rdy), 256'(0));
        check("rst_rd_sad", 256'(rd_sad), 256'(0));
        check("rst_ovf", 256'(ovf), 256'(0));

        // Fill bank 0 and commit on the last beat.
        cyc(1, 1, 5, w4(4, 3, 2, 1), 0, 0, 0, 0);
        cyc(1, 0, 5, w4(16, 17, 18, 19), 0, 0, 0, 0);
        cyc(1, 0, 2, w4(9, 7, 7, 8), 0, 0, 0, 0);
        cyc(1, 0, 6, w4(7, 9, 9, 9), 0, 0, 0, 0);
        check("pre_commit_rd_rdy", 256'(rd_rdy), 256'(0));
        cyc(1, 2, 5, w4(32, 33, 34, 35), 1, 0, 0, 0);
        check("commit_rd_rdy", 256'(rd_rdy), 256'(1));
`ifdef IME_SAD_BUF_MIN_EN
        check("min_p0", 256'(min_sad[SW-1:0]), 256'(7));
        check("min_idx_p0", 256'(min_idx[AW+LW-1:0]), 256'({5'd2, 2'd1}));
`endif
        cyc(0, 0, 0, '0, 0, 1, 5, 0);
        check("read_valid", 256'(rd_valid), 256'(1));
        check("read_p1", 256'(rd_sad[W +: W]), 256'(64'h0004_0003_0002_0001));
        cyc(0, 0, 0, '0, 0, 0, 0, 0);
        check("valid_pulse", 256'(rd_valid), 256'(0));
        check("sad_hold", 256'(rd_sad[W +: W]), 256'(64'h0004_0003_0002_0001));

        // Fill bank 1: both banks committed, then an overflowing write.
        cyc(1, 0, 7, w4(100, 101, 102, 103), 0, 0, 0, 0);
        cyc(1, 1, 7, w4(110, 111, 112, 113), 0, 0, 0, 0);
        cyc(1, 2, 7, w4(120, 121, 122, 123), 1, 0, 0, 0);
        check("full_wr_rdy", 256'(wr_rdy), 256'(0));
        cyc(1, 1, 5, w4(16'hdead, 16'hdead, 16'hdead, 16'hdead), 1, 0, 0, 0);
        check("ovf_set", 256'(ovf), 256'(1));
        cyc(0, 0, 0, '0, 0, 1, 5, 0);
        check("ovf_no_write", 256'(rd_sad[W +: W]), 256'(64'h0004_0003_0002_0001));
        cyc(0, 0, 0, '0, 0, 0, 0, 1);
        check("release_wr_rdy", 256'(wr_rdy), 256'(1));
        check("ovf_sticky", 256'(ovf), 256'(1));

        // Commit and release together; the read in that cycle uses the old bank.
        cyc(1, 0, 9, w4(50, 51, 52, 53), 0, 0, 0, 0);
        cyc(1, 1, 9, w4(60, 61, 62, 63), 0, 0, 0, 0);
        cyc(1, 2, 9, w4(70, 71, 72, 73), 1, 1, 7, 1);
        check("swap_old_bank", 256'(rd_sad[0 +: W]), 256'(w4(100, 101, 102, 103)));
        check("swap_wr_rdy", 256'(wr_rdy), 256'(1));
        check("swap_rd_rdy", 256'(rd_rdy), 256'(1));
        cyc(0, 0, 0, '0, 0, 1, 9, 0);
        check("swap_new_bank", 256'(rd_sad[2*W +: W]), 256'(w4(70, 71, 72, 73)));

        // Out-of-range partition: data dropped, commit still honoured.
        cyc(1, 3, 7, w4(16'hffff, 16'hffff, 16'hffff, 16'hffff), 1, 0, 0, 0);
        check("drop_commit", 256'(wr_rdy), 256'(0));
        cyc(0, 0, 0, '0, 0, 0, 0, 1);
        cyc(0, 0, 0, '0, 0, 1, 7, 0);
        check("drop_p0", 256'(rd_sad[0 +: W]), 256'(w4(100, 101, 102, 103)));
        check("drop_p2", 256'(rd_sad[2*W +: W]), 256'(w4(120, 121, 122, 123)));

        // Reset with both banks committed.
        cyc(1, 0, 3, w4(1, 1, 1, 1), 1, 0, 0, 0);
        check("pre_rst_full", 256'(wr_rdy), 256'(0));
        rstn = 1'b1;
        #1;
        check("rst_mid_rd_rdy", 256'(rd_rdy), 256'(0));
        check("rst_mid_wr_rdy", 256'(wr_rdy), 256'(1));
        check("rst_mid_rd_sad", 256'(rd_sad), 256'(0));
        @(negedge clk); #1;
        rstn = 1'b0;

        // Release and read on an empty buffer are ignored.
        cyc(0, 0, 0, '0, 0, 1, 5, 1);
        check("empty_read_valid", 256'(rd_valid), 256'(0));
        check("empty_rd_rdy", 256'(rd_rdy), 256'(0));
        check("empty_wr_rdy", 256'(wr_rdy), 256'(1));
        cyc(0, 0, 0, '0, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ime_sad_pingpong_buffer.md
# ime_sad_pingpong_buffer

Parametrised, double-buffered SAD store for the IME stage. The SAD tree writes one word of LANES candidate SADs per cycle into one of BLOCKS partitions. The decision stage reads all BLOCKS partitions of the same address in parallel. Two banks ping-pong, so the next CTU's SADs fill one bank while the current CTU's are consumed from the other.

## Interface
Parameters:
- SAD_WIDTH, 16: bits per SAD value
- LANES, 4: SADs per written word
- BLOCKS, 3: partitions per bank; 1..8, need not be a power of two
- DEPTH, 32: words per partition; AW = $clog2(DEPTH), BW = max(1,$clog2(BLOCKS)), LW = max(1,$clog2(LANES))

Ports:
- clk  in  1  clock, all state on rising edge
- rstn  in  1  reset; one clock; asynchronous and active-high (asserted = 1) despite the name
- wr_en_i  in  1  write strobe
- wr_block_i  in  BW  target partition
- wr_addr_i  in  AW  target word
- wr_sad_i  in  LANES*SAD_WIDTH  lane 0 in the LSBs
- wr_last_i  in  1  qualified by wr_en_i; commits the fill bank
- wr_rdy_o  out  1  a fill bank is available
- rd_en_i  in  1  read strobe
- rd_addr_i  in  AW  word to read from every partition
- rd_done_i  in  1  releases the read bank
- rd_rdy_o  out  1  a committed bank is available
- rd_valid_o  out  1  rd_sad_o updated this cycle
- rd_sad_o  out  BLOCKS*LANES*SAD_WIDTH  partition 0 in the LSBs
- ovf_o  out  1  sticky: write or commit attempted while !wr_rdy_o
- min_sad_o, min_idx_o: see Configuration

## Operation
- State: wb (fill bank), rb (read bank), cnt (committed banks, 0..2).
- wr_rdy_o = (cnt<2). rd_rdy_o = (cnt>0).
- Accepted write: wr_en_i & wr_rdy_o & (wr_block_i < BLOCKS). Stores the word at [wb][wr_block_i][wr_addr_i].
  - wr_block_i ≥ BLOCKS: the write is dropped silently. A commit carried on such a beat is still honoured.
- Commit: wr_en_i & wr_last_i & wr_rdy_o. The data write happens, cnt+1, wb toggles.
- Release: rd_done_i & rd_rdy_o. cnt−1, rb toggles. rd_done_i while cnt==0 is ignored.
- Commit and release in the same cycle: cnt unchanged, both pointers toggle.
- wr_en_i while !wr_rdy_o: no memory or pointer change; ovf_o sets and is cleared only by reset.
- Read: rd_en_i & rd_rdy_o fetches word rd_addr_i of all partitions of bank rb. rd_en_i while !rd_rdy_o is ignored; rd_valid_o stays 0.
- Unwritten words return stale contents. No clear-on-commit.
- Memory arrays are not reset.

## Timing
- Reset values: wb=rb=0, cnt=0, wr_rdy_o=1, rd_rdy_o=0, rd_valid_o=0, rd_sad_o=0, ovf_o=0, min_sad_o all-ones, min_idx_o=0.
- Write to read: a word written at edge N is readable by a read issued in cycle N+1 or later, after commit.
- Read latency is 1: rd_sad_o and rd_valid_o are registered. rd_valid_o is a one-cycle pulse. rd_sad_o holds its value between reads.
- A read issued in the same cycle as a release still returns data from the old rb.
- wr_rdy_o and rd_rdy_o are registered functions of cnt and update the cycle after a commit or release.
- Reset asserted mid-fill or mid-read aborts everything immediately. Both banks are treated as empty.

## Configuration
- IME_SAD_BUF_MIN_EN defined: adds min_sad_o (BLOCKS*SAD_WIDTH) and min_idx_o (BLOCKS*(AW+LW), {addr,lane}).
  - A per-partition tracker runs over accepted writes to the fill bank.
  - Comparison is strict less-than, so on ties the lowest lane and the earliest write win.
  - At commit, the trackers, including the committing beat, are latched into the committed-bank copy. The live trackers then reset to all-ones/0.
  - Each bank keeps its own copy. Outputs show the copy for rb and are valid while rd_rdy_o.
- Undefined: neither port exists and no tracker logic is built. All other behaviour is identical.

## Structure
- Shared package/include: SAD_WIDTH default, the BW/AW/LW derivations, and the IME_SAD_BUF_MIN_EN guard name.
- One sub-module, ime_sad_buf_bank: one partition's two-bank DEPTH×(LANES*SAD_WIDTH) array with a synchronous read port. It is instantiated BLOCKS times in a generate loop.
- The pointer/count FSM and the optional min trackers live in the top level.

## Test plan
- Fill bank 0, partition 1, addr 5 with {4,3,2,1}, then commit; read addr 5 → rd_valid_o one cycle later, partition 1 field = {4,3,2,1}, rd_rdy_o=1.
- Commit twice without release → wr_rdy_o=0. A third write sets ovf_o=1 and leaves bank contents unchanged. After release, wr_rdy_o=1 and ovf_o stays 1.
- With cnt=1, commit and release in the same cycle → cnt stays 1, both pointers toggle, and the next read returns the newly committed bank.
- Write with wr_block_i=3 when BLOCKS=3 → dropped; a read of the same addr returns the prior contents.
- Assert reset while cnt=2 → next cycle rd_rdy_o=0, wr_rdy_o=1, rd_sad_o=0.
- With IME_SAD_BUF_MIN_EN, write partition 0 at addr 2 {9,7,7,8} and at addr 6 {7,9,9,9}, then commit → min_sad_o[0]=7, min_idx_o[0]={2,1}.
